rtc_bus_master: RTL and testbench
=================================

RTC_BUS_MASTER -- requirements
Module: rtc_bus_master

Interface
REQ-001 The block SHALL have parameter T_PH, default 4, clocks per bus phase (legal 1..15).
REQ-002 The block SHALL have port clk input 1: single system clock, all logic on rising edge.
REQ-003 The block SHALL have port reset_n input 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start input 1: single-transaction request, sampled in IDLE only.
REQ-005 The block SHALL have port wr input 1: transaction type, 1=write, 0=read, captured with start.
REQ-006 The block SHALL have port addr_in input 8: register address, captured with start.
REQ-007 The block SHALL have port wdata input 8: write data, captured with start.
REQ-008 The block SHALL have port scan input 1: request a read sweep of the 11 display registers.
REQ-009 The block SHALL have port busy output 1: high from acceptance until the done cycle, inclusive.
REQ-010 The block SHALL have port done output 1: one-clock pulse at transaction end.
REQ-011 The block SHALL have port rdata output 8: last read data, held until the next read completes.
REQ-012 The block SHALL have port rd_idx output 4: scan index (0..10) of rdata; 0 for single reads.
REQ-013 The block SHALL have port ad_out output 8: multiplexed address/data bus drive value.
REQ-014 The block SHALL have port ad_oe output 1: bus drive enable, 1=master drives ad_out.
REQ-015 The block SHALL have port ad_in input 8: bus sample value.
REQ-016 The block SHALL have ports cs_n, rd_n, wr_n output 1 each: active-low chip select, read and write strobes.
REQ-017 The block SHALL have port aod output 1: phase indicator, 0=address phase, 1=data phase.

Function
REQ-018 FSM states SHALL be IDLE, ADR, ADR_REC, DAT, DAT_REC, FIN; ADR, ADR_REC, DAT and DAT_REC each last exactly T_PH clocks; FIN lasts 1 clock.
REQ-019 In IDLE, start=1 SHALL capture wr/addr_in/wdata and enter ADR on the next edge; start while busy SHALL be ignored.
REQ-020 In ADR: cs_n=0, wr_n=0, rd_n=1, aod=0, ad_oe=1, ad_out=address. In ADR_REC: wr_n=1, all other bus signals unchanged.
REQ-021 In a write DAT phase: cs_n=0, aod=1, wr_n=0, ad_oe=1, ad_out=data. In a read DAT phase: aod=1, rd_n=0, ad_oe=0.
REQ-022 In a read, ad_in SHALL be registered into rdata on the last clock of DAT; rdata SHALL be unchanged by writes.
REQ-023 In DAT_REC, strobes SHALL be high, cs_n=0 and ad_oe=0; in FIN and IDLE, cs_n=rd_n=wr_n=1, aod=0 and ad_oe=0.
REQ-024 done SHALL be 1 only in FIN; the accept-to-done latency SHALL be 4*T_PH+1 clocks.
REQ-025 All bus outputs SHALL be registered, with no combinational path from inputs to bus outputs.
REQ-026 The phase counter SHALL be 4 bits and reload 0 at each state entry; a phase ends when count==T_PH-1.
REQ-027 Simultaneous start and scan in IDLE SHALL run the single transaction; the scan request SHALL be dropped.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, cs_n=rd_n=wr_n=1, aod=0, ad_oe=0, ad_out=0, busy=0, done=0, rdata=0, rd_idx=0, scan state cleared, including when reset occurs mid-transaction.
REQ-029 After reset release, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 With macro RTC_SCAN_EN defined, scan=1 in IDLE SHALL issue 11 back-to-back reads to 0x21..0x28, 0x41, 0x42 and 0x43; rd_idx SHALL be 0..10, and done SHALL pulse after each read with busy held high until the last one completes; the FIN of read k SHALL go directly to ADR of read k+1.
REQ-031 Without RTC_SCAN_EN, the scan input SHALL be ignored, rd_idx SHALL be tied to 0, and no sequencer logic SHALL exist.

Verification
REQ-032 T_PH=4, write addr 0x21 data 0x45 -> cs_n low 16 clks, ad_out=0x21 with aod=0 for 8 clks, then 0x45 with aod=1; wr_n low clks 1-4 and 9-12; done at clk 17.
REQ-033 Read addr 0x42, ad_in=0x37 during DAT -> rd_n low 4 clks, ad_oe=0 in DAT, rdata=0x37 at done, rd_idx=0.
REQ-034 start pulsed again at clk 5 of an active transaction -> ignored; exactly one done pulse.
REQ-035 reset_n asserted at clk 10 of a write -> bus idle values asynchronously, busy=0; a new start after release completes normally.
REQ-036 RTC_SCAN_EN with ad_in=address+1 -> 11 done pulses with rd_idx 0..10 and rdata 0x22..0x29, 0x42, 0x43, 0x44; busy continuous for 11*(4*T_PH+1) clks.
REQ-037 T_PH=1 read -> latency 5 clks; start and scan in the same cycle -> only the single transaction runs.

Source files
------------

// File: rtl/rtc_bus_master_if.sv
// Signal bundle between rtc_bus_master and its user and RTC chip: the request/response handshake plus the
// multiplexed address/data bus pins.
interface rtc_bus_master_if;
    logic       start;
    logic       wr;
    logic [7:0] addr_in;
    logic [7:0] wdata;
    logic       scan;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [3:0] rd_idx;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       aod;

    modport master (
        input  start, wr, addr_in, wdata, scan, ad_in,
        output busy, done, rdata, rd_idx, ad_out, ad_oe, cs_n, rd_n, wr_n, aod
    );

    modport slave (
        output start, wr, addr_in, wdata, scan, ad_in,
        input  busy, done, rdata, rd_idx, ad_out, ad_oe, cs_n, rd_n, wr_n, aod
    );
endinterface

// File: rtl/rtc_bus_master.sv
// Multiplexed address/data bus master for an RTC chip: one transaction is one address phase followed by one
// data phase. Defining RTC_SCAN_EN adds a sweep that reads all 11 display registers.
// Handshake: start (or scan) is accepted only while busy=0. busy then stays high up to and including the
// single-cycle done pulse. rdata/rd_idx are valid from done until the next read completes.
module rtc_bus_master #(
    parameter int T_PH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    rtc_bus_master_if.master bus,
    output logic [2:0]       state_dbg
);
    typedef enum logic [2:0] {IDLE, ADR, ADR_REC, DAT, DAT_REC, FIN} state_t;
    localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d, wdat_q, wdat_d;
    logic       wr_q, wr_d;
    logic       ph_end;
    logic       cs_n_d, rd_n_d, wr_n_d, aod_d, oe_d, busy_d, done_d;
    logic [7:0] ad_out_d, rdata_d;

`ifdef RTC_SCAN_EN
    logic       scan_act_q, scan_act_d;
    logic [3:0] scan_idx_q, scan_idx_d;
    logic [3:0] rd_idx_d;

    // Display registers: 0x21..0x28 followed by 0x41..0x43.
    function automatic logic [7:0] scan_addr(input logic [3:0] idx);
        if (idx < 4'd8) return 8'h21 + {4'h0, idx};
        return 8'h41 + {4'h0, idx - 4'd8};
    endfunction
`else
    assign bus.rd_idx = '0;
`endif

    assign ph_end    = (cnt_q == PH_LAST);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdat_q     <= '0;
            wr_q       <= 1'b0;
            bus.cs_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.wr_n   <= 1'b1;
            bus.aod    <= 1'b0;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.rdata  <= '0;
`ifdef RTC_SCAN_EN
            scan_act_q <= 1'b0;
            scan_idx_q <= '0;
            bus.rd_idx <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            wr_q       <= wr_d;
            bus.cs_n   <= cs_n_d;
            bus.rd_n   <= rd_n_d;
            bus.wr_n   <= wr_n_d;
            bus.aod    <= aod_d;
            bus.ad_oe  <= oe_d;
            bus.ad_out <= ad_out_d;
            bus.busy   <= busy_d;
            bus.done   <= done_d;
            bus.rdata  <= rdata_d;
`ifdef RTC_SCAN_EN
            scan_act_q <= scan_act_d;
            scan_idx_q <= scan_idx_d;
            bus.rd_idx <= rd_idx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        wr_d    = wr_q;
`ifdef RTC_SCAN_EN
        scan_act_d = scan_act_q;
        scan_idx_d = scan_idx_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // start takes priority, and a scan raised in the same cycle is dropped.
                if (bus.start) begin
                    state_d = ADR;
                    addr_d  = bus.addr_in;
                    wdat_d  = bus.wdata;
                    wr_d    = bus.wr;
                end
`ifdef RTC_SCAN_EN
                else if (bus.scan) begin
                    state_d    = ADR;
                    addr_d     = scan_addr(4'd0);
                    wr_d       = 1'b0;
                    scan_act_d = 1'b1;
                    scan_idx_d = '0;
                end
`endif
            end
            ADR:     if (ph_end) begin state_d = ADR_REC; cnt_d = '0; end
            ADR_REC: if (ph_end) begin state_d = DAT;     cnt_d = '0; end
            DAT:     if (ph_end) begin state_d = DAT_REC; cnt_d = '0; end
            DAT_REC: if (ph_end) begin state_d = FIN;     cnt_d = '0; end
            FIN: begin
                cnt_d   = '0;
                state_d = IDLE;
`ifdef RTC_SCAN_EN
                if (scan_act_q && scan_idx_q != 4'd10) begin
                    state_d    = ADR;
                    scan_idx_d = scan_idx_q + 4'd1;
                    addr_d     = scan_addr(scan_idx_q + 4'd1);
                end else begin
                    scan_act_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus pins are decoded from the next state so that the registered outputs line up with the state.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        aod_d    = 1'b0;
        oe_d     = 1'b0;
        ad_out_d = bus.ad_out;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
        rdata_d  = bus.rdata;
`ifdef RTC_SCAN_EN
        rd_idx_d = bus.rd_idx;
`endif
        case (state_d)
            ADR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                oe_d     = 1'b1;
                ad_out_d = addr_d;
            end
            ADR_REC: begin
                cs_n_d   = 1'b0;
                oe_d     = 1'b1;
                ad_out_d = addr_d;
            end
            DAT: begin
                cs_n_d = 1'b0;
                aod_d  = 1'b1;
                if (wr_d) begin
                    wr_n_d   = 1'b0;
                    oe_d     = 1'b1;
                    ad_out_d = wdat_d;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            DAT_REC: begin
                cs_n_d = 1'b0;
                aod_d  = 1'b1;
            end
            default: ;
        endcase
        if (state_q == DAT && ph_end && !wr_q) begin
            rdata_d = bus.ad_in;
`ifdef RTC_SCAN_EN
            rd_idx_d = scan_act_q ? scan_idx_q : 4'd0;
`endif
        end
    end
endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed-plus-random bench for rtc_bus_master. A T_PH=4 instance carries most of the stimulus, and a
// T_PH=1 instance covers the minimum phase length.
module tb_rtc_bus_master;
    localparam int TP  = 4;
    localparam int TP1 = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    rtc_bus_master_if bus4();
    rtc_bus_master_if bus1();
    logic [2:0] st4, st1;

    rtc_bus_master #(.T_PH(TP))  dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4), .state_dbg(st4));
    rtc_bus_master #(.T_PH(TP1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .state_dbg(st1));

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rdata = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {busy, done, cs_n, rd_n, wr_n, ad_oe} in cycle k (1-based) after acceptance.
    function automatic logic [5:0] exp_pins(input int k, input int t, input logic w);
        int ph;
        ph = (k - 1) / t;
        if (ph == 0) return 6'b100101;
        if (ph == 1) return 6'b100111;
        if (ph == 2) return w ? 6'b100101 : 6'b100010;
        if (ph == 3) return 6'b100110;
        return 6'b111110;
    endfunction

    function automatic logic [5:0] pins4();
        return {bus4.busy, bus4.done, bus4.cs_n, bus4.rd_n, bus4.wr_n, bus4.ad_oe};
    endfunction

    function automatic logic [5:0] pins1();
        return {bus1.busy, bus1.done, bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_oe};
    endfunction

    task automatic check_idle4(input string tag);
        check({tag, "_pins"}, pins4(), 6'b001110);
        check({tag, "_aod"}, bus4.aod, 1'b0);
        check({tag, "_rdata"}, bus4.rdata, last_rdata);
    endtask

    // One single transaction on dut4, checked cycle by cycle, followed by two idle cycles.
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rv,
                           input logic with_scan, input int restart_at);
        int n;
        int ph;
        n = 4 * TP + 1;
        @(negedge clk);
        bus4.start = 1'b1; bus4.wr = w; bus4.addr_in = a; bus4.wdata = d;
        bus4.scan = with_scan; bus4.ad_in = ~rv;
        if (!w) exp_q.push_back(rv);
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus4.scan  = 1'b0;
            bus4.start = (k == restart_at);
            if (k == restart_at) begin
                bus4.wr = ~w; bus4.addr_in = ~a; bus4.wdata = ~d;
            end
            bus4.ad_in = (k == 3 * TP) ? rv : ~rv;
            ph = (k - 1) / TP;
            check("pins", pins4(), exp_pins(k, TP, w));
            if (ph != 3) check("aod", bus4.aod, (ph == 2));
            if (ph < 2) check("ad_out_adr", bus4.ad_out, a);
            if (ph == 2 && w) check("ad_out_dat", bus4.ad_out, d);
            if (!w && k == 3 * TP + 1) last_rdata = exp_q.pop_front();
            check("rdata", bus4.rdata, last_rdata);
            if (k == n) check("rd_idx", bus4.rd_idx, 4'd0);
        end
        bus4.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle4("post");
        end
    endtask

    initial begin
        int lat;
        logic [7:0] a, d, rv;
        bus4.start = 0; bus4.wr = 0; bus4.addr_in = 0; bus4.wdata = 0; bus4.scan = 0; bus4.ad_in = 0;
        bus1.start = 0; bus1.wr = 0; bus1.addr_in = 0; bus1.wdata = 0; bus1.scan = 0; bus1.ad_in = 0;

        #2 reset_n = 1'b0;
        #1;
        check("rst_pins", pins4(), 6'b001110);
        check("rst_aod", bus4.aod, 1'b0);
        check("rst_ad_out", bus4.ad_out, 8'h00);
        check("rst_rdata", bus4.rdata, 8'h00);
        check("rst_rd_idx", bus4.rd_idx, 4'd0);
        check("rst_pins1", pins1(), 6'b001110);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run_txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 0);
        run_txn(1'b0, 8'h42, 8'h00, 8'h37, 1'b0, 0);
        run_txn(1'b1, 8'h30, 8'h99, 8'h00, 1'b0, 0);
        run_txn(1'b1, 8'h55, 8'h66, 8'h00, 1'b0, 5);
        run_txn(1'b0, 8'h24, 8'h00, 8'hc3, 1'b0, 5);

        for (int i = 0; i < 6; i++) begin
            a  = 8'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            rv = 8'($urandom_range(0, 255));
            run_txn(1'($urandom_range(0, 1)), a, d, rv, 1'b0, 0);
        end

        run_txn(1'b0, 8'h27, 8'h00, 8'h5a, 1'b1, 0);

        // Reset in the data phase of a write, then a start on the first edge after release.
        @(negedge clk);
        bus4.start = 1'b1; bus4.wr = 1'b1; bus4.addr_in = 8'h12; bus4.wdata = 8'h34;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        last_rdata = 8'h00;
        exp_q.delete();
        check("midrst_pins", pins4(), 6'b001110);
        check("midrst_aod", bus4.aod, 1'b0);
        check("midrst_ad_out", bus4.ad_out, 8'h00);
        check("midrst_rdata", bus4.rdata, 8'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 0);
        run_txn(1'b0, 8'h43, 8'h00, 8'h81, 1'b0, 0);

`ifdef RTC_SCAN_EN
        @(negedge clk);
        bus4.scan = 1'b1;
        @(posedge clk);
        for (int idx = 0; idx < 11; idx++) begin
            a = (idx < 8) ? 8'(8'h21 + idx) : 8'(8'h41 + idx - 8);
            for (int k = 1; k <= 4 * TP + 1; k++) begin
                @(negedge clk);
                bus4.scan  = 1'b0;
                bus4.ad_in = a + 8'h01;
                check("scan_pins", pins4(), exp_pins(k, TP, 1'b0));
                if ((k - 1) / TP < 2) check("scan_adr", bus4.ad_out, a);
                if (k == 3 * TP + 1) last_rdata = a + 8'h01;
                check("scan_rdata", bus4.rdata, last_rdata);
                if (k == 4 * TP + 1) check("scan_rd_idx", bus4.rd_idx, 4'(idx));
            end
        end
        repeat (2) begin
            @(negedge clk);
            check_idle4("scan_end");
        end
`else
        @(negedge clk);
        bus4.scan = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus4.scan = 1'b0;
            check_idle4("scan_off");
            check("scan_off_rd_idx", bus4.rd_idx, 4'd0);
        end
`endif

        // T_PH=1: start and scan together must run just the single read, 5 clocks after acceptance.
        rv = 8'($urandom_range(0, 255));
        @(negedge clk);
        bus1.start = 1'b1; bus1.wr = 1'b0; bus1.addr_in = 8'h23; bus1.scan = 1'b1; bus1.ad_in = rv;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus1.start = 1'b0;
            bus1.scan  = 1'b0;
            lat++;
        end while (bus1.done !== 1'b1 && lat < 20);
        check("t1_latency", lat, 5);
        check("t1_rdata", bus1.rdata, rv);
        check("t1_rd_idx", bus1.rd_idx, 4'd0);
        repeat (3) begin
            @(negedge clk);
            check("t1_idle", pins1(), 6'b001110);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
